// File: rtl/ball_tracker_if.sv
// Centroid-in / track-out bundle for ball_tracker; the tracker uses the slave modport.
interface ball_tracker_if #(
  parameter int unsigned MAX_BALLS = 7
);
  logic        [8:0]           centroids_x_in [MAX_BALLS-1:0];
  logic        [7:0]           centroids_y_in [MAX_BALLS-1:0];
  logic        [2:0]           num_balls;
  logic                        data_valid_in;
  logic        [8:0]           tracks_x_out   [MAX_BALLS-1:0];
  logic        [7:0]           tracks_y_out   [MAX_BALLS-1:0];
  logic signed [9:0]           vel_x_out      [MAX_BALLS-1:0];
  logic signed [8:0]           vel_y_out      [MAX_BALLS-1:0];
  logic        [MAX_BALLS-1:0] lost_out;
  logic                        data_valid_out;
  logic                        busy_out;
  logic                        dropped_out;

  modport slave (
    input  centroids_x_in, centroids_y_in, num_balls, data_valid_in,
    output tracks_x_out, tracks_y_out, vel_x_out, vel_y_out, lost_out,
    output data_valid_out, busy_out, dropped_out
  );

  modport master (
    output centroids_x_in, centroids_y_in, num_balls, data_valid_in,
    input  tracks_x_out, tracks_y_out, vel_x_out, vel_y_out, lost_out,
    input  data_valid_out, busy_out, dropped_out
  );
endinterface

// File: rtl/ball_tracker.sv
// Frame-to-frame ball tracker: sequential greedy nearest-neighbour matching of centroids to tracks.
// Optional velocity outputs are built only when BALL_TRACKER_VELOCITY_EN is defined.
module ball_tracker #(
  parameter int unsigned MAX_BALLS = 7,
  parameter int unsigned MAX_JUMP  = 64
) (
  input logic           clk_in,
  input logic           rst_in,
  ball_tracker_if.slave bus
);

  localparam int unsigned IDX_W = (MAX_BALLS > 1) ? $clog2(MAX_BALLS) : 1;
  localparam int unsigned NW    = 3;
  localparam int unsigned DW    = 10;

  typedef enum logic [1:0] {S_IDLE, S_MATCH, S_OUTPUT} state_e;

  state_e               state_q, state_d;
  logic                 first_q, first_d;
  logic                 seed_q, seed_d;
  logic [NW-1:0]        n_q, n_d;
  logic [NW-1:0]        prev_n_q, prev_n_d;
  logic [IDX_W-1:0]     t_q, t_d, c_q, c_d;
  logic [DW-1:0]        min_q, min_d;
  logic [IDX_W-1:0]     bidx_q, bidx_d;
  logic [MAX_BALLS-1:0] claim_q, claim_d;
  logic [8:0]           cand_x_q [MAX_BALLS-1:0];
  logic [8:0]           cand_x_d [MAX_BALLS-1:0];
  logic [7:0]           cand_y_q [MAX_BALLS-1:0];
  logic [7:0]           cand_y_d [MAX_BALLS-1:0];
  logic [IDX_W-1:0]     best_q   [MAX_BALLS-1:0];
  logic [IDX_W-1:0]     best_d   [MAX_BALLS-1:0];
  logic [DW-1:0]        dist_q   [MAX_BALLS-1:0];
  logic [DW-1:0]        dist_d   [MAX_BALLS-1:0];
  logic [8:0]           trk_x_q  [MAX_BALLS-1:0];
  logic [8:0]           trk_x_d  [MAX_BALLS-1:0];
  logic [7:0]           trk_y_q  [MAX_BALLS-1:0];
  logic [7:0]           trk_y_d  [MAX_BALLS-1:0];
  logic [MAX_BALLS-1:0] lost_q, lost_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 dropped_q, dropped_d;
`ifdef BALL_TRACKER_VELOCITY_EN
  logic signed [9:0]    vel_x_q  [MAX_BALLS-1:0];
  logic signed [9:0]    vel_x_d  [MAX_BALLS-1:0];
  logic signed [8:0]    vel_y_q  [MAX_BALLS-1:0];
  logic signed [8:0]    vel_y_d  [MAX_BALLS-1:0];
`endif

  logic [8:0]       dx;
  logic [7:0]       dy;
  logic [DW-1:0]    dist_c;
  logic [DW-1:0]    cur_min;
  logic [IDX_W-1:0] cur_best;
  logic [IDX_W-1:0] last_idx;

  // Next-state, datapath and output logic
  always_comb begin
    state_d   = state_q;
    first_d   = first_q;
    seed_d    = seed_q;
    n_d       = n_q;
    prev_n_d  = prev_n_q;
    t_d       = t_q;
    c_d       = c_q;
    min_d     = min_q;
    bidx_d    = bidx_q;
    claim_d   = claim_q;
    cand_x_d  = cand_x_q;
    cand_y_d  = cand_y_q;
    best_d    = best_q;
    dist_d    = dist_q;
    trk_x_d   = trk_x_q;
    trk_y_d   = trk_y_q;
    lost_d    = lost_q;
`ifdef BALL_TRACKER_VELOCITY_EN
    vel_x_d   = vel_x_q;
    vel_y_d   = vel_y_q;
`endif
    valid_d   = 1'b0;
    dropped_d = bus.data_valid_in && (state_q != S_IDLE);
    last_idx  = IDX_W'(n_q - 3'd1);

    dx = (trk_x_q[t_q] >= cand_x_q[c_q]) ? (trk_x_q[t_q] - cand_x_q[c_q])
                                          : (cand_x_q[c_q] - trk_x_q[t_q]);
    dy = (trk_y_q[t_q] >= cand_y_q[c_q]) ? (trk_y_q[t_q] - cand_y_q[c_q])
                                          : (cand_y_q[c_q] - trk_y_q[t_q]);
    dist_c   = DW'(dx) + DW'(dy);
    cur_min  = (c_q == '0) ? {DW{1'b1}} : min_q;
    cur_best = (c_q == '0) ? '0 : bidx_q;

    case (state_q)
      S_IDLE: begin
        if (bus.data_valid_in) begin
          for (int unsigned i = 0; i < MAX_BALLS; i++) begin
            cand_x_d[i] = bus.centroids_x_in[i];
            cand_y_d[i] = bus.centroids_y_in[i];
          end
          n_d     = bus.num_balls;
          t_d     = '0;
          c_d     = '0;
          claim_d = '0;
          if (first_q || (bus.num_balls != prev_n_q) || (bus.num_balls == '0)) begin
            seed_d  = 1'b1;
            state_d = S_OUTPUT;
          end else begin
            seed_d  = 1'b0;
            state_d = S_MATCH;
          end
        end
      end

      S_MATCH: begin
        // Strict less-than keeps the lowest-index candidate on ties
        if (!claim_q[c_q] && (dist_c < cur_min)) begin
          cur_min  = dist_c;
          cur_best = c_q;
        end
        min_d  = cur_min;
        bidx_d = cur_best;
        if (c_q == last_idx) begin
          claim_d[cur_best] = 1'b1;
          best_d[t_q]       = cur_best;
          dist_d[t_q]       = cur_min;
          c_d               = '0;
          t_d               = t_q + IDX_W'(1);
          if (t_q == last_idx) begin
            state_d = S_OUTPUT;
          end
        end else begin
          c_d = c_q + IDX_W'(1);
        end
      end

      S_OUTPUT: begin
        for (int unsigned i = 0; i < MAX_BALLS; i++) begin
          trk_x_d[i] = '0;
          trk_y_d[i] = '0;
          lost_d[i]  = 1'b0;
`ifdef BALL_TRACKER_VELOCITY_EN
          vel_x_d[i] = '0;
          vel_y_d[i] = '0;
`endif
          if (NW'(i) < n_q) begin
            if (seed_q) begin
              trk_x_d[i] = cand_x_q[i];
              trk_y_d[i] = cand_y_q[i];
            end else if (dist_q[i] <= DW'(MAX_JUMP)) begin
              trk_x_d[i] = cand_x_q[best_q[i]];
              trk_y_d[i] = cand_y_q[best_q[i]];
`ifdef BALL_TRACKER_VELOCITY_EN
              vel_x_d[i] = $signed({1'b0, cand_x_q[best_q[i]]}) - $signed({1'b0, trk_x_q[i]});
              vel_y_d[i] = $signed({1'b0, cand_y_q[best_q[i]]}) - $signed({1'b0, trk_y_q[i]});
`endif
            end else begin
              trk_x_d[i] = trk_x_q[i];
              trk_y_d[i] = trk_y_q[i];
              lost_d[i]  = 1'b1;
            end
          end
        end
        prev_n_d = n_q;
        first_d  = 1'b0;
        valid_d  = 1'b1;
        state_d  = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= S_IDLE;
      first_q   <= 1'b1;
      seed_q    <= 1'b0;
      n_q       <= '0;
      prev_n_q  <= '0;
      t_q       <= '0;
      c_q       <= '0;
      min_q     <= '0;
      bidx_q    <= '0;
      claim_q   <= '0;
      lost_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      dropped_q <= 1'b0;
      for (int unsigned i = 0; i < MAX_BALLS; i++) begin
        cand_x_q[i] <= '0;
        cand_y_q[i] <= '0;
        best_q[i]   <= '0;
        dist_q[i]   <= '0;
        trk_x_q[i]  <= '0;
        trk_y_q[i]  <= '0;
`ifdef BALL_TRACKER_VELOCITY_EN
        vel_x_q[i]  <= '0;
        vel_y_q[i]  <= '0;
`endif
      end
    end else begin
      state_q   <= state_d;
      first_q   <= first_d;
      seed_q    <= seed_d;
      n_q       <= n_d;
      prev_n_q  <= prev_n_d;
      t_q       <= t_d;
      c_q       <= c_d;
      min_q     <= min_d;
      bidx_q    <= bidx_d;
      claim_q   <= claim_d;
      lost_q    <= lost_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      dropped_q <= dropped_d;
      cand_x_q  <= cand_x_d;
      cand_y_q  <= cand_y_d;
      best_q    <= best_d;
      dist_q    <= dist_d;
      trk_x_q   <= trk_x_d;
      trk_y_q   <= trk_y_d;
`ifdef BALL_TRACKER_VELOCITY_EN
      vel_x_q   <= vel_x_d;
      vel_y_q   <= vel_y_d;
`endif
    end
  end

  assign bus.tracks_x_out   = trk_x_q;
  assign bus.tracks_y_out   = trk_y_q;
  assign bus.lost_out       = lost_q;
  assign bus.data_valid_out = valid_q;
  assign bus.busy_out       = busy_q;
  assign bus.dropped_out    = dropped_q;

`ifdef BALL_TRACKER_VELOCITY_EN
  assign bus.vel_x_out = vel_x_q;
  assign bus.vel_y_out = vel_y_q;
`else
  for (genvar g = 0; g < MAX_BALLS; g++) begin : g_no_vel
    assign bus.vel_x_out[g] = '0;
    assign bus.vel_y_out[g] = '0;
  end
`endif

endmodule

// File: tb/tb_ball_tracker.sv
// Directed scoreboard bench for ball_tracker: seed, permutation, lost gate, tie, overflow, reset abort.
module tb_ball_tracker;

  localparam int unsigned NB = 7;
`ifdef BALL_TRACKER_VELOCITY_EN
  localparam bit VEL_EN = 1'b1;
`else
  localparam bit VEL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ball_tracker_if #(.MAX_BALLS(NB)) bus ();

  ball_tracker #(.MAX_BALLS(NB), .MAX_JUMP(64)) dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (bus)
  );

  typedef struct packed {
    logic [NB-1:0][8:0] x;
    logic [NB-1:0][7:0] y;
    logic [NB-1:0][9:0] vx;
    logic [NB-1:0][8:0] vy;
    logic [NB-1:0]      lost;
    int                 lat;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input logic [31:0] got, input logic [31:0] exp, input string tag);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic exp_t slot(input exp_t s, input int i, input int x, input int y,
                                input int vx, input int vy);
    exp_t r = s;
    r.x[i]  = 9'(x);
    r.y[i]  = 8'(y);
    r.vx[i] = VEL_EN ? 10'(vx) : 10'd0;
    r.vy[i] = VEL_EN ? 9'(vy) : 9'd0;
    return r;
  endfunction

  task automatic check_outputs(input exp_t s, input string tag);
    for (int i = 0; i < NB; i++) begin
      chk(32'(bus.tracks_x_out[i]), 32'(s.x[i]), $sformatf("%s trk_x[%0d]", tag, i));
      chk(32'(bus.tracks_y_out[i]), 32'(s.y[i]), $sformatf("%s trk_y[%0d]", tag, i));
      chk({22'd0, bus.vel_x_out[i]}, 32'(s.vx[i]), $sformatf("%s vel_x[%0d]", tag, i));
      chk({23'd0, bus.vel_y_out[i]}, 32'(s.vy[i]), $sformatf("%s vel_y[%0d]", tag, i));
    end
    chk(32'(bus.lost_out), 32'(s.lost), {tag, " lost"});
  endtask

  // Unused slots carry nonzero data so slot forcing is visible
  task automatic clear_cands();
    for (int i = 0; i < NB; i++) begin
      bus.centroids_x_in[i] = 9'd311;
      bus.centroids_y_in[i] = 8'd177;
    end
  endtask

  task automatic cand(input int i, input int x, input int y);
    bus.centroids_x_in[i] = 9'(x);
    bus.centroids_y_in[i] = 8'(y);
  endtask

  task automatic run_frame(input int n, input int drop_at, input string tag);
    exp_t s;
    int   cyc;
    bit   seen;
    @(negedge clk);
    bus.num_balls     = 3'(n);
    bus.data_valid_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.data_valid_in = 1'b0;
    chk(32'(bus.busy_out), 32'd1, {tag, " busy"});
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 200) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (drop_at > 0 && cyc == drop_at) begin
        for (int i = 0; i < NB; i++) begin
          bus.centroids_x_in[i] = 9'($urandom_range(319));
          bus.centroids_y_in[i] = 8'($urandom_range(179));
        end
        bus.num_balls     = 3'd2;
        bus.data_valid_in = 1'b1;
      end
      if (drop_at > 0 && cyc == drop_at + 1) begin
        chk(32'(bus.dropped_out), 32'd1, {tag, " dropped"});
        bus.data_valid_in = 1'b0;
      end
      seen = bus.data_valid_out;
    end
    s = sb.pop_front();
    chk(32'(seen), 32'd1, {tag, " output seen"});
    if (seen) begin
      chk(32'(cyc), 32'(s.lat), {tag, " latency"});
      check_outputs(s, tag);
      @(negedge clk);
      chk(32'(bus.data_valid_out), 32'd0, {tag, " valid pulse width"});
      chk(32'(bus.busy_out), 32'd0, {tag, " idle after"});
      check_outputs(s, {tag, " hold"});
    end
  endtask

  initial begin
    rst_n             = 1'b0;
    bus.data_valid_in = 1'b0;
    bus.num_balls     = 3'd0;
    clear_cands();
    repeat (3) @(posedge clk);
    @(negedge clk);
    e = '0;
    check_outputs(e, "reset");
    chk(32'(bus.data_valid_out), 32'd0, "reset valid");
    chk(32'(bus.busy_out), 32'd0, "reset busy");
    chk(32'(bus.dropped_out), 32'd0, "reset dropped");
    rst_n = 1'b1;

    // Seed after reset
    clear_cands();
    cand(0, 10, 20); cand(1, 100, 50); cand(2, 200, 90);
    e = '0; e.lat = 1;
    e = slot(e, 0, 10, 20, 0, 0); e = slot(e, 1, 100, 50, 0, 0); e = slot(e, 2, 200, 90, 0, 0);
    sb.push_back(e);
    run_frame(3, 0, "seed");

    // Permuted input order
    clear_cands();
    cand(0, 203, 92); cand(1, 12, 21); cand(2, 98, 55);
    e = '0; e.lat = 10;
    e = slot(e, 0, 12, 21, 2, 1); e = slot(e, 1, 98, 55, -2, 5); e = slot(e, 2, 203, 92, 3, 2);
    sb.push_back(e);
    run_frame(3, 0, "perm");

    // Track 0 jumps 80 px: lost, holds position
    clear_cands();
    cand(0, 205, 93); cand(1, 12, 101); cand(2, 100, 57);
    e = '0; e.lat = 10; e.lost = 7'b0000001;
    e = slot(e, 0, 12, 21, 0, 0); e = slot(e, 1, 100, 57, 2, 2); e = slot(e, 2, 205, 93, 2, 1);
    sb.push_back(e);
    run_frame(3, 0, "lost");

    // Count change 3 -> 4 reseeds
    clear_cands();
    cand(0, 50, 50); cand(1, 250, 150); cand(2, 10, 170); cand(3, 300, 5);
    e = '0; e.lat = 1;
    e = slot(e, 0, 50, 50, 0, 0); e = slot(e, 1, 250, 150, 0, 0);
    e = slot(e, 2, 10, 170, 0, 0); e = slot(e, 3, 300, 5, 0, 0);
    sb.push_back(e);
    run_frame(4, 0, "count");

    // Equidistant candidates: lower index wins
    clear_cands();
    cand(0, 40, 50); cand(1, 60, 50); cand(2, 11, 171); cand(3, 251, 151);
    e = '0; e.lat = 17; e.lost = 7'b0001000;
    e = slot(e, 0, 40, 50, -10, 0); e = slot(e, 1, 251, 151, 1, 1);
    e = slot(e, 2, 11, 171, 1, 1);  e = slot(e, 3, 300, 5, 0, 0);
    sb.push_back(e);
    run_frame(4, 0, "tie");

    // Gate boundary 64 kept / 65 lost, with a dropped frame mid-match
    clear_cands();
    cand(0, 104, 50); cand(1, 251, 151); cand(2, 11, 171); cand(3, 300, 70);
    e = '0; e.lat = 17; e.lost = 7'b0001000;
    e = slot(e, 0, 104, 50, 64, 0); e = slot(e, 1, 251, 151, 0, 0);
    e = slot(e, 2, 11, 171, 0, 0);  e = slot(e, 3, 300, 5, 0, 0);
    sb.push_back(e);
    run_frame(4, 5, "gate_drop");

    // N = 0 seeds and clears every slot
    clear_cands();
    e = '0; e.lat = 1;
    sb.push_back(e);
    run_frame(0, 0, "zero");

    // Reseed from N = 0 with extreme coordinates
    clear_cands();
    cand(0, 30, 40); cand(1, 60, 80); cand(2, 90, 120); cand(3, 319, 179);
    e = '0; e.lat = 1;
    e = slot(e, 0, 30, 40, 0, 0); e = slot(e, 1, 60, 80, 0, 0);
    e = slot(e, 2, 90, 120, 0, 0); e = slot(e, 3, 319, 179, 0, 0);
    sb.push_back(e);
    run_frame(4, 0, "reseed");

    // Abort a match with asynchronous reset
    clear_cands();
    cand(0, 31, 41); cand(1, 61, 81); cand(2, 91, 121); cand(3, 318, 178);
    @(negedge clk);
    bus.num_balls     = 3'd4;
    bus.data_valid_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.data_valid_in = 1'b0;
    chk(32'(bus.busy_out), 32'd1, "abort busy");
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    e = '0;
    check_outputs(e, "abort");
    chk(32'(bus.busy_out), 32'd0, "abort busy cleared");
    chk(32'(bus.data_valid_out), 32'd0, "abort valid");
    @(negedge clk);
    rst_n = 1'b1;

    // Same N after reset still seeds
    clear_cands();
    cand(0, 5, 6); cand(1, 7, 8); cand(2, 9, 10); cand(3, 11, 12);
    e = '0; e.lat = 1;
    e = slot(e, 0, 5, 6, 0, 0); e = slot(e, 1, 7, 8, 0, 0);
    e = slot(e, 2, 9, 10, 0, 0); e = slot(e, 3, 11, 12, 0, 0);
    sb.push_back(e);
    run_frame(4, 0, "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
